pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer_pkg.sv | 20 ++
 rtl/pll_reset_sequencer_sync.sv | 30 +++
 rtl/pll_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared types for the PLL reset sequencer.
//   seq_state_e : sequencer state encoding
//   max_int     : constant helper used to size the shared cycle counter
// Cycle counts are deliberately not kept here; they stay parameters of the
// sequencer so that each instance can be tuned to its own PLL.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_2ff: two-flop synchronizer for slow asynchronous status inputs
// (lock indicators, link-up flags and the like). Both flops clear on reset,
// so the synchronized value reads 0 until two clock edges after release.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   d    - asynchronous input(s)
//   q    - synchronized output(s), two-cycle latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a stable lock and only
// then releases the downstream system reset. Failed attempts are retried a
// bounded number of times before parking in FAULT.
// Ports:
//   refclk    - board reference clock (also feeds the PLL), sole clock
//   rst       - asynchronous active-high reset
//   locked    - PLL lock indicator, asynchronous to refclk
//   restart   - one-cycle soft restart request (refclk domain)
//   pll_rst   - PLL reset, active-high
//   sys_rst   - downstream system reset, active-high (refclk domain)
//   ready     - high only while running
//   fault     - high only in FAULT
//   retry_cnt - failed lock attempts since the last RUN entry or restart
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             locked,
  input  logic                             restart,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int CNT_MAX = max_int(RST_PULSE_CYCLES, max_int(LOCK_TIMEOUT_CYCLES, STABLE_CYCLES));
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  // Terminal counts: each state leaves on the last cycle of its window.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = '1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  seq_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_next;
  logic               cnt_clr;
  logic               locked_s;
  logic               pll_rst_next, sys_rst_next, ready_next, fault_next;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state logic. A failed attempt either loops back to PLL_RESET with
  // one more retry counted, or gives up into FAULT once the budget is spent.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_cnt;
    cnt_clr    = 1'b0;

    if (restart) begin
      // Restart outranks everything evaluated below on the same cycle.
      state_next = ST_PLL_RESET;
      retry_next = '0;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_PLL_RESET: begin
          if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = ST_STABLE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_PLL_RESET;
              retry_next = retry_cnt + 1'b1;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_PLL_RESET;
              retry_next = retry_cnt + 1'b1;
            end
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            retry_next = '0;
          end
        end
        ST_RUN: begin
          // Lock loss after a good bring-up is not a failed attempt.
          if (!locked_s) state_next = ST_PLL_RESET;
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          state_next = ST_PLL_RESET;
        end
      endcase
    end

    // Shared counter restarts at 0 in every newly entered state and parks
    // at all-ones rather than wrapping (only FAULT and RUN dwell that long).
    if (cnt_clr || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_SAT) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state register.
    pll_rst_next = (state_next == ST_PLL_RESET) || (state_next == ST_FAULT);
    sys_rst_next = (state_next != ST_RUN);
    ready_next   = (state_next == ST_RUN);
    fault_next   = (state_next == ST_FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_PLL_RESET;
      cnt_reg   <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_cnt <= retry_next;
      pll_rst   <= pll_rst_next;
      sys_rst   <= sys_rst_next;
      ready     <= ready_next;
      fault     <= fault_next;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed, table-driven bench for the PLL reset
// sequencer with small cycle parameters (pulse 4, timeout 20, stable 8,
// 2 retries). Each table row drives the inputs, advances a number of refclk
// edges and compares all outputs against hand-computed values. The async
// reset in the middle of STABLE is a hand-written sequence between tables.
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       locked;
    logic       restart;
    int         cycles;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry;
  } vec_t;

  vec_t vecs[$];
  int   vec_id = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .STABLE_CYCLES       (SC),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #5 refclk = ~refclk;

  // sys_rst must never be released while the PLL is held in reset.
  always @(negedge refclk) begin
    if (!rst) begin
      checks++;
      if (!sys_rst && pll_rst) begin
        errors++;
        $display("FAIL invariant t=%0t: sys_rst=%b while pll_rst=%b, required sys_rst=1", $time, sys_rst, pll_rst);
      end
    end
  end

  task automatic add(input logic r, input logic l, input logic rs, input int n,
                     input logic ep, input logic es, input logic er,
                     input logic ef, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.locked = l; v.restart = rs; v.cycles = n;
    v.pll_rst = ep; v.sys_rst = es; v.ready = er; v.fault = ef; v.retry = ec;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {pll_rst, sys_rst, ready, fault, retry_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry_cnt=%0d, required pll_rst=%b sys_rst=%b ready=%b fault=%b retry_cnt=%0d",
               name, got[5], got[4], got[3], got[2], got[1:0],
               exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      locked  = vecs[i].locked;
      restart = vecs[i].restart;
      step(vecs[i].cycles);
      check_outputs($sformatf("vec%0d", vec_id),
                    {vecs[i].pll_rst, vecs[i].sys_rst, vecs[i].ready, vecs[i].fault, vecs[i].retry});
      $display("vec%0d: rst=%b locked=%b restart=%b +%0d cyc -> pll_rst=%b sys_rst=%b ready=%b fault=%b retry_cnt=%0d",
               vec_id, vecs[i].rst, vecs[i].locked, vecs[i].restart, vecs[i].cycles,
               pll_rst, sys_rst, ready, fault, retry_cnt);
      vec_id++;
    end
    vecs.delete();
  endtask

  initial begin
    //   rst lck rs cyc  pll sys rdy flt retry
    // Reset state, then nominal bring-up: 4-cycle pulse, lock 5 cycles later.
    add(1, 0, 0,  2,  1, 1, 0, 0, 0);
    add(0, 0, 0,  3,  1, 1, 0, 0, 0);  // pulse still high after 3 edges
    add(0, 0, 0,  1,  0, 1, 0, 0, 0);  // released on the 4th edge
    add(0, 0, 0,  5,  0, 1, 0, 0, 0);
    add(0, 1, 0, 10,  0, 1, 0, 0, 0);  // 10 edges after lock: not yet
    add(0, 1, 0,  1,  0, 0, 1, 0, 0);  // 11th edge: 2 sync + 8 stable + 1
    add(0, 1, 0,  5,  0, 0, 1, 0, 0);
    // Lock loss in RUN: reaction on the 3rd edge, no retry counted.
    add(0, 0, 0,  2,  0, 0, 1, 0, 0);
    add(0, 0, 0,  1,  1, 1, 0, 0, 0);
    add(0, 0, 0,  3,  1, 1, 0, 0, 0);
    add(0, 0, 0,  1,  0, 1, 0, 0, 0);
    // Relock, then a 3-cycle glitch inside STABLE.
    add(0, 1, 0,  4,  0, 1, 0, 0, 0);
    add(0, 0, 0,  2,  0, 1, 0, 0, 0);
    add(0, 0, 0,  1,  1, 1, 0, 0, 1);
    add(0, 1, 0,  3,  1, 1, 0, 0, 1);
    add(0, 1, 0,  1,  0, 1, 0, 0, 1);
    add(0, 1, 0,  8,  0, 1, 0, 0, 1);
    add(0, 1, 0,  1,  0, 0, 1, 0, 0);  // RUN entry clears retry_cnt
    // Permanent lock loss: three attempts, then FAULT.
    add(0, 0, 0,  3,  1, 1, 0, 0, 0);
    add(0, 0, 0,  4,  0, 1, 0, 0, 0);
    add(0, 0, 0, 19,  0, 1, 0, 0, 0);  // last cycle of the lock window
    add(0, 0, 0,  1,  1, 1, 0, 0, 1);
    add(0, 0, 0, 24,  1, 1, 0, 0, 2);
    add(0, 0, 0, 23,  0, 1, 0, 0, 2);
    add(0, 0, 0,  1,  1, 1, 0, 1, 2);
    add(0, 0, 0, 10,  1, 1, 0, 1, 2);  // FAULT holds
    // Restart out of FAULT.
    add(0, 0, 1,  1,  1, 1, 0, 0, 0);
    add(0, 0, 0,  4,  0, 1, 0, 0, 0);
    // One timeout, then restart on the exact cycle of the second timeout.
    add(0, 0, 0, 43,  0, 1, 0, 0, 1);
    add(0, 0, 1,  1,  1, 1, 0, 0, 0);  // retry_cnt 0, not 2
    add(0, 0, 0,  3,  1, 1, 0, 0, 0);
    add(0, 0, 0,  1,  0, 1, 0, 0, 0);
    // Reach STABLE with one retry on record.
    add(0, 0, 0, 20,  1, 1, 0, 0, 1);
    add(0, 0, 0,  4,  0, 1, 0, 0, 1);
    add(0, 1, 0,  5,  0, 1, 0, 0, 1);
    run_table();

    // Async reset between edges in STABLE: outputs must change before the
    // next refclk edge.
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst_mid_stable", 6'b11_0_0_00);
    $display("async_rst: t=%0t pll_rst=%b sys_rst=%b ready=%b fault=%b retry_cnt=%0d",
             $time, pll_rst, sys_rst, ready, fault, retry_cnt);

    // Release with lock already present: full pulse again, then bring-up.
    add(1, 1, 0,  2,  1, 1, 0, 0, 0);
    add(0, 1, 0,  3,  1, 1, 0, 0, 0);
    add(0, 1, 0,  1,  0, 1, 0, 0, 0);
    add(0, 1, 0,  8,  0, 1, 0, 0, 0);
    add(0, 1, 0,  1,  0, 0, 1, 0, 0);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
